// File: rtl/if_id_stage_pkg.sv
// -----------------------------------------------------------------------------
// if_id_stage_pkg
//   Shared pipeline definitions for the fetch stage and the decode-side
//   Control block. It holds:
//     - the reset PC and the bubble instruction word
//     - the opcode and funct field bit positions
//     - the PC step
//     - the IF/ID register record type
//     - small helpers for PC arithmetic and field extraction
// -----------------------------------------------------------------------------
package if_id_stage_pkg;

    localparam logic [31:0] RESET_PC  = 32'h0040_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

    // Instruction field positions, shared with Control.
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc_plus4;
        logic        valid;
    } ifid_t;

    localparam ifid_t IFID_BUBBLE = '{
        instruction: NOP_INSTR,
        pc_plus4:    32'h0000_0000,
        valid:       1'b0
    };

    // Sequential fetch address. The addition wraps naturally at 2^32.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

    // Redirect targets are forced onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

    function automatic logic [5:0] opcode_of(input logic [31:0] instr);
        return instr[OPCODE_MSB:OPCODE_LSB];
    endfunction

    function automatic logic [5:0] funct_of(input logic [31:0] instr);
        return instr[FUNCT_MSB:FUNCT_LSB];
    endfunction

endpackage

// File: rtl/if_id_stage_pc_reg.sv
// -----------------------------------------------------------------------------
// pc_reg
//   Program counter register with its next-PC mux.
//   Priority, highest first:
//     1. redirect - load the word-aligned target
//     2. stall    - hold the current value
//     3. default  - advance by 4
//
//   Ports
//     clk         in   clock
//     rst_n       in   asynchronous active-low reset; loads RESET_PC
//     stall       in   hold request from the hazard unit
//     redirect    in   branch / jump / jr taken
//     redirect_pc in   target address; the low two bits are ignored
//     pc          out  current fetch address
// -----------------------------------------------------------------------------
module pc_reg
    import if_id_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    always_comb begin
        pc_d = pc_plus4(pc_q);
        if (redirect) begin
            pc_d = word_align(redirect_pc);
        end else if (stall) begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/if_id_stage.sv
// -----------------------------------------------------------------------------
// if_id_stage
//   Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS
//   pipeline.
//
//   Ports
//     clk               in   single clock, rising edge
//     rst_n             in   asynchronous active-low reset
//     IMemAddr          out  instruction memory address (equals PC)
//     IMemData          in   instruction word read combinationally at IMemAddr
//     Stall             in   freezes PC and IF/ID
//     Flush             in   loads a bubble into IF/ID; overrides Stall
//     Redirect          in   loads PC from RedirectPC; overrides Stall
//     RedirectPC        in   branch / jump / jr target
//     PC                out  current fetch address
//     IFID_Instruction  out  registered instruction
//     IFID_PCPlus4      out  registered fetch address + 4
//     IFID_Valid        out  IF/ID holds a real instruction
//     IFID_OpCode       out  IFID_Instruction[31:26]
//     IFID_Funct        out  IFID_Instruction[5:0]
//     FetchCount        out  number of instructions accepted into IF/ID
// -----------------------------------------------------------------------------
module if_id_stage
    import if_id_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] IMemAddr,
    input  logic [31:0] IMemData,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic [31:0] PC,
    output logic [31:0] IFID_Instruction,
    output logic [31:0] IFID_PCPlus4,
    output logic        IFID_Valid,
    output logic [5:0]  IFID_OpCode,
    output logic [5:0]  IFID_Funct,
    output logic [31:0] FetchCount
);

    logic [31:0] pc;
    ifid_t       ifid_q;
    ifid_t       ifid_d;
    logic [31:0] fetch_count_q;
    logic [31:0] fetch_count_d;
    logic        capture;

    pc_reg u_pc_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (Stall),
        .redirect    (Redirect),
        .redirect_pc (RedirectPC),
        .pc          (pc)
    );

    // Redirect does not stop the capture. The word at the old PC is the
    // branch delay slot and still enters decode unless Flush kills it.
    assign capture = !Flush && !Stall;

    always_comb begin
        ifid_d = ifid_q;
        if (Flush) begin
            ifid_d = IFID_BUBBLE;
        end else if (capture) begin
            ifid_d.instruction = IMemData;
            ifid_d.pc_plus4    = pc_plus4(pc);
            ifid_d.valid       = 1'b1;
        end
    end

    always_comb begin
        fetch_count_d = fetch_count_q;
        if (capture) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_q        <= IFID_BUBBLE;
            fetch_count_q <= 32'd0;
        end else begin
            ifid_q        <= ifid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign IMemAddr         = pc;
    assign PC               = pc;
    assign IFID_Instruction = ifid_q.instruction;
    assign IFID_PCPlus4     = ifid_q.pc_plus4;
    assign IFID_Valid       = ifid_q.valid;
    assign IFID_OpCode      = opcode_of(ifid_q.instruction);
    assign IFID_Funct       = funct_of(ifid_q.instruction);
    assign FetchCount       = fetch_count_q;

endmodule

// File: tb/tb_if_id_stage.sv
// -----------------------------------------------------------------------------
// tb_if_id_stage
//   Directed test of if_id_stage. The instruction memory returns an
//   address-tagged word (address XOR a fixed pattern), so every captured word
//   identifies the PC that fetched it.
// -----------------------------------------------------------------------------
module tb_if_id_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] IMemAddr;
    logic [31:0] IMemData;
    logic        Stall;
    logic        Flush;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic [31:0] PC;
    logic [31:0] IFID_Instruction;
    logic [31:0] IFID_PCPlus4;
    logic        IFID_Valid;
    logic [5:0]  IFID_OpCode;
    logic [5:0]  IFID_Funct;
    logic [31:0] FetchCount;

    int checks = 0;
    int errors = 0;

    if_id_stage dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .IMemAddr         (IMemAddr),
        .IMemData         (IMemData),
        .Stall            (Stall),
        .Flush            (Flush),
        .Redirect         (Redirect),
        .RedirectPC       (RedirectPC),
        .PC               (PC),
        .IFID_Instruction (IFID_Instruction),
        .IFID_PCPlus4     (IFID_PCPlus4),
        .IFID_Valid       (IFID_Valid),
        .IFID_OpCode      (IFID_OpCode),
        .IFID_Funct       (IFID_Funct),
        .FetchCount       (FetchCount)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    assign IMemData = mem_word(IMemAddr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [31:0] e_pc,
                               input logic [31:0] e_instr, input logic [31:0] e_pcp4,
                               input logic e_valid, input logic [31:0] e_cnt);
        logic [31:0] ei;
        ei = e_instr;
        check_val({tag, ".pc"},     PC,               e_pc);
        check_val({tag, ".imem"},   IMemAddr,         e_pc);
        check_val({tag, ".instr"},  IFID_Instruction, e_instr);
        check_val({tag, ".pcp4"},   IFID_PCPlus4,     e_pcp4);
        check_val({tag, ".valid"},  {31'd0, IFID_Valid}, {31'd0, e_valid});
        check_val({tag, ".opcode"}, {26'd0, IFID_OpCode}, {26'd0, ei[31:26]});
        check_val({tag, ".funct"},  {26'd0, IFID_Funct},  {26'd0, ei[5:0]});
        check_val({tag, ".count"},  FetchCount,       e_cnt);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        Stall      = 1'b0;
        Flush      = 1'b0;
        Redirect   = 1'b0;
        RedirectPC = 32'h0;

        #12;
        check_state("reset", 32'h0040_0000, 32'h0, 32'h0, 1'b0, 32'd0);
        rst_n = 1'b1;

        // Free run.
        tick;
        check_state("run1", 32'h0040_0004, mem_word(32'h0040_0000), 32'h0040_0004, 1'b1, 32'd1);
        tick;
        check_state("run2", 32'h0040_0008, mem_word(32'h0040_0004), 32'h0040_0008, 1'b1, 32'd2);

        // Three stalled edges at PC 0x0040_0008.
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            check_state("stall", 32'h0040_0008, mem_word(32'h0040_0004), 32'h0040_0008, 1'b1, 32'd2);
        end
        Stall = 1'b0;
        tick;
        check_state("resume", 32'h0040_000C, mem_word(32'h0040_0008), 32'h0040_000C, 1'b1, 32'd3);

        // Redirect with delay slot; low bits of target dropped.
        Redirect   = 1'b1;
        RedirectPC = 32'h0040_0103;
        tick;
        check_state("redir", 32'h0040_0100, mem_word(32'h0040_000C), 32'h0040_0010, 1'b1, 32'd4);
        Redirect = 1'b0;
        tick;
        check_state("target", 32'h0040_0104, mem_word(32'h0040_0100), 32'h0040_0104, 1'b1, 32'd5);

        // Redirect + Flush + Stall: PC takes target, IF/ID becomes a bubble.
        Redirect   = 1'b1;
        Flush      = 1'b1;
        Stall      = 1'b1;
        RedirectPC = 32'h0040_0200;
        tick;
        check_state("rfs", 32'h0040_0200, 32'h0, 32'h0, 1'b0, 32'd5);
        Redirect = 1'b0;
        Flush    = 1'b0;
        Stall    = 1'b0;
        tick;
        check_state("after_rfs", 32'h0040_0204, mem_word(32'h0040_0200), 32'h0040_0204, 1'b1, 32'd6);

        // Redirect + Stall without Flush: PC moves, IF/ID holds.
        Redirect   = 1'b1;
        Stall      = 1'b1;
        RedirectPC = 32'h0040_0300;
        tick;
        check_state("rs", 32'h0040_0300, mem_word(32'h0040_0200), 32'h0040_0204, 1'b1, 32'd6);
        Redirect = 1'b0;
        Stall    = 1'b0;
        tick;
        check_state("after_rs", 32'h0040_0304, mem_word(32'h0040_0300), 32'h0040_0304, 1'b1, 32'd7);

        // Flush alone: bubble, PC advances.
        Flush = 1'b1;
        tick;
        check_state("flush", 32'h0040_0308, 32'h0, 32'h0, 1'b0, 32'd7);
        Flush = 1'b0;

        // PC wrap.
        Redirect   = 1'b1;
        RedirectPC = 32'hFFFF_FFFF;
        tick;
        check_state("to_top", 32'hFFFF_FFFC, mem_word(32'h0040_0308), 32'h0040_030C, 1'b1, 32'd8);
        Redirect = 1'b0;
        tick;
        check_state("wrap", 32'h0000_0000, mem_word(32'hFFFF_FFFC), 32'h0000_0000, 1'b1, 32'd9);
        tick;
        check_state("post_wrap", 32'h0000_0004, mem_word(32'h0000_0000), 32'h0000_0004, 1'b1, 32'd10);

        // Asynchronous reset mid-cycle during a stall.
        Stall = 1'b1;
        tick;
        check_state("pre_rst", 32'h0000_0004, mem_word(32'h0000_0000), 32'h0000_0004, 1'b1, 32'd10);
        #3;
        rst_n = 1'b0;
        #1;
        check_state("async_rst", 32'h0040_0000, 32'h0, 32'h0, 1'b0, 32'd0);
        tick;
        check_state("in_rst", 32'h0040_0000, 32'h0, 32'h0, 1'b0, 32'd0);
        #3;
        rst_n = 1'b1;
        Stall = 1'b0;
        tick;
        check_state("restart", 32'h0040_0004, mem_word(32'h0040_0000), 32'h0040_0004, 1'b1, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_id_stage.md
# if_id_stage

Instruction-fetch stage and IF/ID pipeline register for the 5-stage MIPS pipeline. Holds the program counter, drives the instruction-memory address, and registers the fetched word and PC+4 for the decode stage. The `OpCode` and `Funct` fields it exports feed the `Control` decoder directly. Stall, flush and redirect inputs come from the hazard unit and the branch/jump resolution logic.

## Interface
- `RESET_PC`, 32'h0040_0000, PC value loaded on reset.
- `NOP_INSTR`, 32'h0000_0000, instruction word inserted as a bubble.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `IMemAddr` out 32: instruction memory address; always equals `PC`.
- `IMemData` in 32: instruction word; combinational read of `IMemAddr` in the same cycle.
- `Stall` in 1: load-use hold; freezes `PC` and the IF/ID register.
- `Flush` in 1: replaces the IF/ID contents with a bubble at the next edge.
- `Redirect` in 1: loads `PC` from `RedirectPC` at the next edge.
- `RedirectPC` in 32: branch, jump or jr target.
- `PC` out 32: current fetch address.
- `IFID_Instruction` out 32: registered instruction.
- `IFID_PCPlus4` out 32: registered fetch address + 4.
- `IFID_Valid` out 1: 1 when the IF/ID register holds a real instruction.
- `IFID_OpCode` out 6: `IFID_Instruction[31:26]`.
- `IFID_Funct` out 6: `IFID_Instruction[5:0]`.
- `FetchCount` out 32: count of instructions accepted into IF/ID.

## Operation
- Reset (asynchronous, while `rst_n`=0):
  - `PC`=`RESET_PC`.
  - `IFID_Instruction`=`NOP_INSTR`, `IFID_PCPlus4`=0, `IFID_Valid`=0.
  - `FetchCount`=0.
- PC update at each edge, highest priority first:
  - `Redirect`=1: `PC` <= {`RedirectPC`[31:2], 2'b00}. Low two bits are silently cleared.
  - else `Stall`=1: `PC` holds.
  - else: `PC` <= `PC`+4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
- IF/ID update at each edge, highest priority first:
  - `Flush`=1: load a bubble (`NOP_INSTR`, PCPlus4=0, Valid=0). Flush overrides Stall.
  - else `Stall`=1: hold all IF/ID fields.
  - else: capture `IMemData`, `PC`+4, and Valid=1.
- `Redirect`=1 with `Stall`=0 and `Flush`=0: IF/ID still captures the word at the current `PC`. This is the branch delay slot and is intended.
- `Redirect`=1 with `Stall`=1: `PC` redirects and IF/ID holds, unless `Flush` is also set.
- `FetchCount` increments by 1 on each edge where IF/ID captures (Valid loaded 1). It wraps at 2^32.
- `IFID_OpCode` and `IFID_Funct` are pure slices of the register; they add no extra latency.

## Timing
- Fetch latency is one cycle: the word at `PC` in cycle n appears on `IFID_Instruction` in cycle n+1.
- Redirect latency is one cycle: `PC` equals the target in the cycle after `Redirect` is sampled. The target's instruction appears on IF/ID one cycle after that.
- All control inputs are sampled only at the rising edge. There is no combinational path from `Stall`, `Flush` or `Redirect` to any output.
- Reset deassertion takes effect asynchronously. Sequential updates start at the first rising edge with `rst_n`=1.
- Reset mid-stream discards all in-flight state. No partial update occurs.

## Structure
- The shared pipeline definitions include holds `RESET_PC`, `NOP_INSTR` and the opcode/funct field bit positions, which are also used by `Control`.
- One sub-module, `pc_reg`: the PC register with its redirect/stall/increment mux.
- The IF/ID register and `FetchCount` sit in the top level.

## Test plan
- Reset then free-run, with memory returning address-tagged words:
  - `PC` steps 0x0040_0000, 0x0040_0004, ….
  - IF/ID shows the word for the previous `PC`, `IFID_PCPlus4` = previous `PC`+4, Valid=1.
  - `FetchCount` = 1, 2, 3, ….
- `Stall` high for 3 cycles at `PC`=0x0040_0008:
  - `PC` and IF/ID are frozen for 3 cycles and `FetchCount` does not change.
  - Fetch resumes at 0x0040_0008 with no word skipped or duplicated.
- `Redirect`=1, `RedirectPC`=0x0040_0103, `Flush`=0:
  - the next `PC` is 0x0040_0100.
  - the delay-slot word (from the old `PC`) is captured with Valid=1.
- `Redirect` and `Flush` together with `Stall`=1:
  - `PC` takes the target.
  - IF/ID becomes a bubble: Instruction=0, Valid=0, OpCode=0, Funct=0.
  - `FetchCount` is unchanged.
- PC wrap: redirect to 0xFFFF_FFFC, then run free. The next `PC` is 0x0000_0000 and `IFID_PCPlus4`=0x0000_0000.
- Assert `rst_n`=0 asynchronously mid-cycle during a stall:
  - outputs return to their reset values immediately, without waiting for a clock edge.
  - after release, fetch restarts at `RESET_PC`.
